// File: rtl/storebuffer_mc.sv
// Multi-commit store buffer: in-order speculative stores, up to COMMIT_WIDTH
// commits per cycle, valid/ready drain to the D-cache and byte-wise load forwarding.
module storebuffer_mc #(
   parameter int unsigned SB_SIZE      = 4,
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [ADDR_WIDTH-1:0]             in_addr_i,
   input  logic [DATA_WIDTH-1:0]             in_data_i,
   input  logic [DATA_WIDTH/8-1:0]           in_strb_i,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_cnt_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [ADDR_WIDTH-1:0]             out_addr_o,
   output logic [DATA_WIDTH-1:0]             out_data_o,
   output logic [DATA_WIDTH/8-1:0]           out_strb_o,
   input  logic [ADDR_WIDTH-1:0]             ld_addr_i,
   output logic [DATA_WIDTH-1:0]             fwd_data_o,
   output logic [DATA_WIDTH/8-1:0]           fwd_mask_o,
   output logic [$clog2(SB_SIZE):0]          count_o,
   output logic [$clog2(SB_SIZE):0]          committed_o
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFS    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(SB_SIZE);
   localparam int unsigned PTR_W  = IDX_W + 1;
   // Line-tag compare ignores the byte offset within a data word
   localparam logic [ADDR_WIDTH-1:0] TAG_MASK = ~ADDR_WIDTH'((64'd1 << OFS) - 64'd1);

   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_cmt;
   logic [PTR_W-1:0]      r_tail;
   logic [ADDR_WIDTH-1:0] r_addr [SB_SIZE];
   logic [DATA_WIDTH-1:0] r_data [SB_SIZE];
   logic [STRB_W-1:0]     r_strb [SB_SIZE];
   logic [SB_SIZE-1:0]    r_valid;

   logic [PTR_W-1:0]      w_count;
   logic [PTR_W-1:0]      w_committed;
   logic [PTR_W-1:0]      w_uncommitted;
   logic [PTR_W-1:0]      w_eff;
   logic [IDX_W-1:0]      w_head_idx;
   logic [IDX_W-1:0]      w_cmt_idx;
   logic [IDX_W-1:0]      w_tail_idx;
   logic [SB_SIZE-1:0]    w_kill;
   logic                  w_push;
   logic                  w_pop;

   assign w_count       = r_head - r_tail;
   assign w_committed   = r_cmt - r_tail;
   assign w_uncommitted = r_head - r_cmt;
   assign w_head_idx    = r_head[IDX_W-1:0];
   assign w_cmt_idx     = r_cmt[IDX_W-1:0];
   assign w_tail_idx    = r_tail[IDX_W-1:0];

   assign in_ready_o  = (w_count != PTR_W'(SB_SIZE)) && !flush_i;
   assign w_push      = in_valid_i && in_ready_o;
   assign out_valid_o = (w_committed != '0);
   assign w_pop       = out_valid_o && out_ready_i;

   assign out_addr_o  = r_addr[w_tail_idx];
   assign out_data_o  = r_data[w_tail_idx];
   assign out_strb_o  = r_strb[w_tail_idx];
   assign count_o     = w_count;
   assign committed_o = w_committed;

   // Commit advance, clamped to the entries that were uncommitted at cycle start
   always_comb begin
      w_eff = '0;
      if (!flush_i) begin
         if (32'(commit_cnt_i) < 32'(w_uncommitted)) begin
            w_eff = PTR_W'(commit_cnt_i);
         end else begin
            w_eff = w_uncommitted;
         end
      end
   end

   // Entries in [cmt, head) that a flush discards
   always_comb begin
      logic [IDX_W-1:0] v_ofs;
      v_ofs  = '0;
      w_kill = '0;
      for (int unsigned i = 0; i < SB_SIZE; i++) begin
         v_ofs     = IDX_W'(i) - w_cmt_idx;
         w_kill[i] = flush_i && ({1'b0, v_ofs} < w_uncommitted);
      end
   end

   // Walk oldest to youngest so the youngest matching byte wins
   always_comb begin
      logic [IDX_W-1:0] v_idx;
      v_idx      = '0;
      fwd_data_o = '0;
      fwd_mask_o = '0;
      for (int unsigned k = 0; k < SB_SIZE; k++) begin
         v_idx = w_tail_idx + IDX_W'(k);
         if (r_valid[v_idx] && (((r_addr[v_idx] ^ ld_addr_i) & TAG_MASK) == '0)) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
               if (r_strb[v_idx][b]) begin
                  fwd_mask_o[b]        = 1'b1;
                  fwd_data_o[b*8 +: 8] = r_data[v_idx][b*8 +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_cmt   <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         for (int unsigned i = 0; i < SB_SIZE; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_strb[i] <= '0;
         end
      end else begin
         if (flush_i) begin
            r_head <= r_cmt;
         end else if (w_push) begin
            r_head <= r_head + PTR_W'(1);
         end
         r_cmt <= r_cmt + w_eff;
         if (w_pop) begin
            r_tail <= r_tail + PTR_W'(1);
         end
         for (int unsigned i = 0; i < SB_SIZE; i++) begin
            if (w_kill[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_valid[w_tail_idx] <= 1'b0;
         end
         if (w_push) begin
            r_valid[w_head_idx] <= 1'b1;
            r_addr[w_head_idx]  <= in_addr_i;
            r_data[w_head_idx]  <= in_data_i;
            r_strb[w_head_idx]  <= in_strb_i;
         end
      end
   end

endmodule

// File: tb/tb_storebuffer_mc.sv
// Scoreboard bench for storebuffer_mc: stimulus queues expected drains on commit,
// a negedge monitor pops and compares on every drain handshake.
module tb_storebuffer_mc;

   localparam int unsigned SB   = 4;
   localparam int unsigned CW   = 2;
   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = DW / 8;
   localparam int unsigned CNTW = $clog2(CW + 1);
   localparam int unsigned PW   = $clog2(SB) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [AW-1:0]   in_addr_i;
   logic [DW-1:0]   in_data_i;
   logic [SW-1:0]   in_strb_i;
   logic [CNTW-1:0] commit_cnt_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [AW-1:0]   out_addr_o;
   logic [DW-1:0]   out_data_o;
   logic [SW-1:0]   out_strb_o;
   logic [AW-1:0]   ld_addr_i;
   logic [DW-1:0]   fwd_data_o;
   logic [SW-1:0]   fwd_mask_o;
   logic [PW-1:0]   count_o;
   logic [PW-1:0]   committed_o;

   storebuffer_mc #(.SB_SIZE(SB), .COMMIT_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_strb_i(in_strb_i),
      .commit_cnt_i(commit_cnt_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
      .ld_addr_i(ld_addr_i), .fwd_data_o(fwd_data_o), .fwd_mask_o(fwd_mask_o),
      .count_o(count_o), .committed_o(committed_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } st_t;

   st_t m_unc[$];
   st_t exp_q[$];
   st_t mon_e;
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Drain monitor: every handshake must match the oldest committed store
   always @(negedge clk) begin
      if (!rst && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL drain_unexpected: addr 0x%0h with empty scoreboard", out_addr_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("drain_addr", 64'(out_addr_o), 64'(mon_e.a));
            chk("drain_data", 64'(out_data_o), 64'(mon_e.d));
            chk("drain_strb", 64'(out_strb_o), 64'(mon_e.s));
         end
      end
   end

   // One clock of stimulus; the model tracks committed/uncommitted stores
   task automatic cyc(input bit pv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int cc, input bit rdy, input bit fl);
      bit exp_rdy;
      int eff;
      st_t e;
      exp_rdy      = ((exp_q.size() + m_unc.size()) != SB) && !fl;
      in_valid_i   = pv;
      in_addr_i    = a;
      in_data_i    = d;
      in_strb_i    = s;
      commit_cnt_i = CNTW'(cc);
      out_ready_i  = rdy;
      flush_i      = fl;
      #1;
      if (pv) chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
      if (!fl && cc > m_unc.size())
         $display("note: protocol violation flagged, commit_cnt_i=%0d uncommitted=%0d", cc, m_unc.size());
      eff = fl ? 0 : ((cc < m_unc.size()) ? cc : m_unc.size());
      for (int k = 0; k < eff; k++) exp_q.push_back(m_unc.pop_front());
      if (fl) m_unc.delete();
      if (pv && exp_rdy) begin
         e.a = a; e.d = d; e.s = s;
         m_unc.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid_i   = 1'b0;
      commit_cnt_i = '0;
      flush_i      = 1'b0;
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) cyc(1'b0, 32'h0, 32'h0, 4'h0, 0, rdy, 1'b0);
   endtask

   task automatic chk_model();
      chk("count_model", 64'(count_o), 64'(exp_q.size() + m_unc.size()));
      chk("committed_model", 64'(committed_o), 64'(exp_q.size()));
   endtask

   task automatic drain_all();
      int g;
      g = 0;
      while (m_unc.size() > 0)
         cyc(1'b0, 32'h0, 32'h0, 4'h0, (m_unc.size() > 1) ? 2 : 1, 1'b1, 1'b0);
      while (exp_q.size() > 0 && g < 50) begin
         idle(1, 1'b1);
         g++;
      end
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d stores still pending", exp_q.size());
      end
      chk("drained_count", 64'(count_o), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_addr_i = '0; in_data_i = '0;
      in_strb_i = '0; commit_cnt_i = '0; out_ready_i = 1'b0; ld_addr_i = 32'h100;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_committed", 64'(committed_o), 64'd0);
      chk("rst_out_addr", 64'(out_addr_o), 64'd0);
      chk("rst_out_data", 64'(out_data_o), 64'd0);
      chk("rst_fwd_mask", 64'(fwd_mask_o), 64'd0);
      chk("rst_fwd_data", 64'(fwd_data_o), 64'd0);

      // Fill to full, commit 2+2, drain in order
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 0, 1'b1, 1'b0);
      chk("full_count", 64'(count_o), 64'd4);
      chk("full_ready", 64'(in_ready_o), 64'd0);
      cyc(1'b1, 32'h110, 32'hBAD0_BAD0, 4'hF, 2, 1'b1, 1'b0);
      chk("cmt2_committed", 64'(committed_o), 64'd2);
      chk("cmt2_count", 64'(count_o), 64'd4);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b1, 1'b0);
      chk("cmt4_count", 64'(count_o), 64'd3);
      chk("cmt4_committed", 64'(committed_o), 64'd3);
      idle(3, 1'b1);
      chk("fill_end_count", 64'(count_o), 64'd0);
      chk("fill_end_valid", 64'(out_valid_o), 64'd0);

      // Flush keeps the committed entry only
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'h400 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b0, 1'b1);
      chk("flush_count", 64'(count_o), 64'd1);
      chk("flush_committed", 64'(committed_o), 64'd1);
      ld_addr_i = 32'h404;
      #1 chk("flush_killed_fwd", 64'(fwd_mask_o), 64'd0);
      ld_addr_i = 32'h400;
      #1 chk("flush_kept_fwd_mask", 64'(fwd_mask_o), 64'hF);
      chk("flush_kept_fwd_data", 64'(fwd_data_o), 64'hC000_0000);
      idle(1, 1'b1);
      chk("flush_drained", 64'(count_o), 64'd0);
      cyc(1'b1, 32'h40C, 32'hC000_000C, 4'hF, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("post_flush_count", 64'(count_o), 64'd0);

      // Byte-wise forwarding: youngest store wins per byte
      cyc(1'b1, 32'h200, 32'h1122_3344, 4'hF, 0, 1'b0, 1'b0);
      cyc(1'b1, 32'h200, 32'hAABB_CCDD, 4'h3, 0, 1'b0, 1'b0);
      ld_addr_i = 32'h202;
      #1 chk("fwd_merge_data", 64'(fwd_data_o), 64'h1122_CCDD);
      chk("fwd_merge_mask", 64'(fwd_mask_o), 64'hF);
      ld_addr_i = 32'h300;
      #1 chk("fwd_miss_mask", 64'(fwd_mask_o), 64'h0);
      chk("fwd_miss_data", 64'(fwd_data_o), 64'h0);
      ld_addr_i  = 32'h200;
      in_valid_i = 1'b1; in_addr_i = 32'h200; in_data_i = 32'h5566_7788; in_strb_i = 4'hC;
      #1 chk("fwd_excl_push", 64'(fwd_data_o), 64'h1122_CCDD);
      cyc(1'b1, 32'h200, 32'h5566_7788, 4'hC, 0, 1'b0, 1'b0);
      chk("fwd_after_push", 64'(fwd_data_o), 64'h5566_CCDD);
      chk("fwd_count", 64'(count_o), 64'd3);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b1, 1'b0);
      idle(3, 1'b1);
      chk("fwd_end_count", 64'(count_o), 64'd0);

      // Wrap-around with toggling backpressure
      for (int r = 0; r < 10; r++) begin
         cyc(1'b1, 32'h500 + 32'(4 * r), 32'h5000_0000 + 32'(r), 4'hF,
             (m_unc.size() > 0) ? 1 : 0, 1'(r % 2), 1'b0);
         chk_model();
         chk("wrap_full_flag", 64'(in_ready_o), 64'((exp_q.size() + m_unc.size()) != SB));
      end
      drain_all();

      // Over-commit clamps; drain output is stable under backpressure
      cyc(1'b1, 32'h600, 32'h6666_0000, 4'h5, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b0, 1'b0);
      chk("ovc_committed", 64'(committed_o), 64'd1);
      chk("ovc_count", 64'(count_o), 64'd1);
      for (int i = 0; i < 5; i++) begin
         idle(1, 1'b0);
         chk("stall_valid", 64'(out_valid_o), 64'd1);
         chk("stall_addr", 64'(out_addr_o), 64'h600);
         chk("stall_data", 64'(out_data_o), 64'h6666_0000);
         chk("stall_strb", 64'(out_strb_o), 64'h5);
      end
      idle(1, 1'b1);
      chk("ovc_end_count", 64'(count_o), 64'd0);

      // Reset in the middle of operation
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'h700 + 32'(4 * i), 32'h7000_0000 + 32'(i), 4'hF, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 2, 1'b0, 1'b0);
      ld_addr_i = 32'h700;
      #1 chk("pre_rst_fwd", 64'(fwd_mask_o), 64'hF);
      chk("pre_rst_committed", 64'(committed_o), 64'd2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      m_unc.delete();
      exp_q.delete();
      chk("mid_rst_count", 64'(count_o), 64'd0);
      chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
      chk("mid_rst_ready", 64'(in_ready_o), 64'd1);
      chk("mid_rst_fwd", 64'(fwd_mask_o), 64'd0);
      chk("mid_rst_committed", 64'(committed_o), 64'd0);
      cyc(1'b1, 32'h800, 32'h8888_8888, 4'hF, 0, 1'b0, 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 4'h0, 1, 1'b1, 1'b0);
      idle(2, 1'b1);
      chk("final_count", 64'(count_o), 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
